// File: rtl/countdown_timer_if.sv
`default_nettype none
// ============================================================================
// Module   : countdown_timer_if
// Brief    : Control/status bundle for countdown_timer.
// Revision : 1.0
// ============================================================================
interface countdown_timer_if #(
    parameter int WIDTH = 4
);
    logic             ld;
    logic [WIDTH-1:0] ldvalue;
    logic             start;
    logic             en;
    logic [WIDTH-1:0] dout;
    logic             busy;
    logic             done;
    logic             zero;

    modport master (
        output ld, ldvalue, start, en,
        input  dout, busy, done, zero
    );

    modport slave (
        input  ld, ldvalue, start, en,
        output dout, busy, done, zero
    );
endinterface
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
// Module   : countdown_timer
// Brief    : Loadable down-counter with pause, done pulse and optional reload.
// Revision : 1.0
// ============================================================================
module countdown_timer #(
    parameter int WIDTH       = 4,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  wire logic         clk,
    input  wire logic         reset,
    countdown_timer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] c_ZERO = '0;
    localparam logic [WIDTH-1:0] c_ONE  = WIDTH'(1);

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic             r_busy;
    logic             r_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_count  <= c_ZERO;
            r_reload <= c_ZERO;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (bus.ld) begin
            r_state  <= IDLE;
            r_count  <= bus.ldvalue;
            r_reload <= bus.ldvalue;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start && (r_count != c_ZERO)) begin
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (!bus.en) begin
                        r_state <= PAUSE;
                    end else if (r_count <= c_ONE) begin
                        // Saturate at zero so the count can never wrap to all-ones
                        r_count <= c_ZERO;
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_count <= r_count - c_ONE;
                    end
                end
                PAUSE: begin
                    if (bus.en) begin
                        r_state <= RUN;
                    end
                end
                DONE: begin
                    r_done <= 1'b0;
                    if (AUTO_RELOAD && (r_reload != c_ZERO)) begin
                        r_count <= r_reload;
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dout = r_count;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.zero = (r_count == c_ZERO);

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_countdown_timer
// Brief    : Randomized scoreboard bench, one-shot and auto-reload instances.
// Revision : 1.0
// ============================================================================
module tb_countdown_timer;

    logic clk;
    logic reset;

    countdown_timer_if #(.WIDTH(4)) if0 ();
    countdown_timer_if #(.WIDTH(4)) if1 ();

    countdown_timer #(.WIDTH(4), .AUTO_RELOAD(1'b0)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0)
    );

    countdown_timer #(.WIDTH(4), .AUTO_RELOAD(1'b1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int k;
        int dout;
        bit busy;
        bit done;
        bit zero;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Reference model: per-instance count, reload value and activity flags
    int m_cnt[2];
    int m_rel[2];
    bit m_running[2];
    bit m_paused[2];
    bit m_fired[2];

    // Stimulus words: {rst_n, ld, start, en, ldvalue[3:0]}
    logic [7:0] stim[$];
    bit   cur_rst, cur_ld, cur_start, cur_en;
    int   cur_v;

    task automatic add(input bit r, input bit l, input bit s, input bit e,
                       input int v, input int n);
        for (int i = 0; i < n; i++) stim.push_back({r, l, s, e, 4'(v)});
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_rel[k] = 0;
            m_running[k] = 0; m_paused[k] = 0; m_fired[k] = 0;
        end
    endtask

    task automatic model_edge(input int k);
        bit ar;
        ar = (k == 1);
        if (cur_ld) begin
            m_cnt[k] = cur_v; m_rel[k] = cur_v;
            m_running[k] = 0; m_paused[k] = 0; m_fired[k] = 0;
        end else if (m_fired[k]) begin
            m_fired[k] = 0;
            if (ar && m_rel[k] != 0) begin
                m_cnt[k] = m_rel[k];
                m_running[k] = 1;
            end
        end else if (m_paused[k]) begin
            if (cur_en) begin
                m_paused[k] = 0; m_running[k] = 1;
            end
        end else if (m_running[k]) begin
            if (!cur_en) begin
                m_running[k] = 0; m_paused[k] = 1;
            end else begin
                m_cnt[k] = m_cnt[k] - 1;
                if (m_cnt[k] == 0) begin
                    m_running[k] = 0; m_fired[k] = 1;
                end
            end
        end else if (cur_start && m_cnt[k] != 0) begin
            m_running[k] = 1;
        end
    endtask

    task automatic push_expected();
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            e.k    = k;
            e.dout = m_cnt[k];
            e.busy = m_running[k] | m_paused[k];
            e.done = m_fired[k];
            e.zero = (m_cnt[k] == 0);
            sb.push_back(e);
        end
    endtask

    task automatic drive(input logic [7:0] w);
        {cur_rst, cur_ld, cur_start, cur_en} = w[7:4];
        cur_v = int'(w[3:0]);
        reset = cur_rst;
        if0.ld = cur_ld; if0.start = cur_start; if0.en = cur_en; if0.ldvalue = w[3:0];
        if1.ld = cur_ld; if1.start = cur_start; if1.en = cur_en; if1.ldvalue = w[3:0];
    endtask

    // Monitor: every DUT output is live each cycle, so drain all pending expectations
    initial begin
        exp_t e;
        int   ad;
        bit   ab, adn, az;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.k == 0) begin
                    ad = int'(if0.dout); ab = if0.busy; adn = if0.done; az = if0.zero;
                end else begin
                    ad = int'(if1.dout); ab = if1.busy; adn = if1.done; az = if1.zero;
                end
                n_cmp++;
                if (ad != e.dout || ab != e.busy || adn != e.done || az != e.zero) begin
                    n_fail++;
                    $display("FAIL dut%0d t=%0t actual dout=%0d busy=%0b done=%0b zero=%0b required dout=%0d busy=%0b done=%0b zero=%0b",
                             e.k, $time, ad, ab, adn, az, e.dout, e.busy, e.done, e.zero);
                end
            end
        end
    end

    initial begin
        logic [7:0] w;
        int         r;

        // Directed scenarios
        add(0, 0, 0, 0, 0, 2);                       // reset
        add(1, 0, 1, 1, 0, 1);                       // start with count 0: ignored
        add(1, 1, 0, 0, 3, 1); add(1, 0, 1, 1, 0, 1); add(1, 0, 0, 1, 0, 6);
        add(1, 1, 0, 0, 5, 1); add(1, 0, 1, 1, 0, 1); add(1, 0, 0, 1, 0, 2);
        add(1, 0, 0, 0, 0, 3); add(1, 0, 0, 1, 0, 6);  // pause then resume
        add(1, 1, 0, 0, 2, 1); add(1, 0, 1, 1, 0, 1); add(1, 0, 0, 1, 0, 8);
        add(1, 1, 0, 1, 15, 1); add(1, 0, 1, 1, 0, 1); add(1, 0, 0, 1, 0, 18);
        add(1, 1, 0, 1, 6, 1); add(1, 0, 1, 1, 0, 1); add(1, 0, 0, 1, 0, 2);
        add(0, 0, 0, 1, 0, 1);                       // async reset mid-countdown
        add(1, 0, 1, 1, 0, 2);                       // start without new ld: ignored
        add(1, 1, 0, 1, 6, 1); add(1, 0, 1, 1, 0, 1); add(1, 0, 0, 1, 0, 2);
        add(1, 1, 1, 1, 7, 1);                       // ld beats start
        add(1, 0, 0, 1, 0, 3); add(1, 0, 1, 1, 0, 1); add(1, 0, 1, 1, 0, 10);

        // Randomized stimulus
        for (int i = 0; i < 1500; i++) begin
            r = int'($urandom_range(0, 99));
            w[7]   = (r != 0);
            w[6]   = ($urandom_range(0, 11) == 0);
            w[5]   = ($urandom_range(0, 4) == 0);
            w[4]   = ($urandom_range(0, 5) != 0);
            w[3:0] = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            stim.push_back(w);
        end

        drive(8'h00);
        model_reset();
        #1;
        push_expected();

        while (stim.size() > 0) begin
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                if (!cur_rst) begin
                    model_reset();
                end else begin
                    model_edge(k);
                end
            end
            #1;
            drive(stim.pop_front());
            if (!cur_rst) model_reset();             // reset acts without a clock edge
            #1;
            push_expected();
        end

        @(negedge clk);
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain actual pending=%0d required pending=0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
